// File: rtl/afe_config_sequencer.sv
// Walks the command ROM and shifts each 24-bit word to the AFE over SPI mode 0, MSB first; readback capture under AFE_CFG_READBACK_EN.
// Latency: first CSN fall 3 cycles after start; CSN low 48*CLK_DIV cycles per word; done 3 cycles after start on an empty ROM.
// Backpressure: none; start is ignored while busy, and the ROM is assumed to answer one cycle after each address change.
module afe_config_sequencer #(
   parameter int          CLK_DIV      = 4,
   parameter int          NUM_COMMANDS = 8,
   parameter logic [23:0] END_MARKER   = 24'hFFFFFF,
   parameter int          GAP_CYCLES   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic [7:0]  rom_address,
   input  logic [23:0] rom_command,
   output logic        spi_sclk,
   output logic        spi_csn,
   output logic        spi_sdo,
   input  logic        spi_sdi,
   output logic        busy,
   output logic        done,
   output logic [7:0]  command_count,
   output logic [23:0] readback_data,
   output logic        readback_valid
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      GAP,
      FINISH
   } state_t;

   state_t state, next_state;

   logic [23:0] shift_reg;
   logic [15:0] div_cnt;
   logic [15:0] gap_cnt;
   logic [4:0]  bit_cnt;

   logic div_last, bit_last, gap_last, addr_last, is_marker;
   logic shift_tick, frame_end;

   assign div_last   = (div_cnt == 16'(CLK_DIV - 1));
   assign bit_last   = (bit_cnt == 5'd23);
   assign gap_last   = (gap_cnt == 16'(GAP_CYCLES - 1));
   assign addr_last  = (rom_address == 8'(NUM_COMMANDS - 1));
   assign is_marker  = (rom_command == END_MARKER);
   assign shift_tick = (state == SHIFT) && div_last;
   assign frame_end  = shift_tick && spi_sclk && bit_last;

   // The shift register is cleared between frames, so its MSB doubles as the idle-low data line.
   assign spi_sdo = shift_reg[23];

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = FETCH;
         FETCH:   next_state = LOAD;
         LOAD:    next_state = is_marker ? FINISH : SHIFT;
         SHIFT:   if (frame_end) next_state = GAP;
         GAP:     if (gap_last) next_state = addr_last ? FINISH : FETCH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rom_address   <= '0;
         spi_sclk      <= 1'b0;
         spi_csn       <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         command_count <= '0;
         shift_reg     <= '0;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         gap_cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rom_address   <= '0;
                  command_count <= '0;
                  busy          <= 1'b1;
               end
            end
            LOAD: begin
               if (is_marker) begin
                  done <= 1'b1;
               end else begin
                  shift_reg <= rom_command;
                  spi_csn   <= 1'b0;
                  spi_sclk  <= 1'b0;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
               end
            end
            SHIFT: begin
               if (!div_last) begin
                  div_cnt <= div_cnt + 16'd1;
               end else begin
                  div_cnt <= '0;
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                  end else begin
                     // Falling SCLK: either advance to the next bit or close the frame.
                     spi_sclk <= 1'b0;
                     if (bit_last) begin
                        spi_csn       <= 1'b1;
                        shift_reg     <= '0;
                        command_count <= command_count + 8'd1;
                        gap_cnt       <= '0;
                     end else begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        bit_cnt   <= bit_cnt + 5'd1;
                     end
                  end
               end
            end
            GAP: begin
               if (!gap_last)      gap_cnt     <= gap_cnt + 16'd1;
               else if (addr_last) done        <= 1'b1;
               else                rom_address <= rom_address + 8'd1;
            end
            FINISH: busy <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef AFE_CFG_READBACK_EN
   logic [23:0] capture_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         capture_reg    <= '0;
         readback_data  <= '0;
         readback_valid <= 1'b0;
      end else begin
         readback_valid <= 1'b0;
         if (shift_tick && !spi_sclk)
            capture_reg <= {capture_reg[22:0], spi_sdi};
         // Bit 0 was captured CLK_DIV cycles earlier, so the word is complete at CSN rise.
         if (frame_end) begin
            readback_data  <= capture_reg;
            readback_valid <= 1'b1;
         end
      end
   end
`else
   logic unused_sdi;
   assign unused_sdi     = spi_sdi;
   assign readback_data  = '0;
   assign readback_valid = 1'b0;
`endif

endmodule

// File: tb/tb_afe_config_sequencer.sv
// Bench for afe_config_sequencer: timeline model checked every cycle plus literal frame/latency checks.
// Latency: runs at CLK_DIV=2, GAP_CYCLES=4, so each SPI word occupies 96 CSN-low cycles.
// Backpressure: none; the bench ROM answers one cycle after each address change.
module tb_afe_config_sequencer;

   localparam int          D   = 2;
   localparam int          G   = 4;
   localparam int          NC  = 8;
   localparam logic [23:0] EM  = 24'hFFFFFF;
   localparam logic [23:0] TXW = 24'hA5C3F0;
`ifdef AFE_CFG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, start;
   logic [7:0]  rom_address;
   logic [23:0] rom_command;
   logic        spi_sclk, spi_csn, spi_sdo, spi_sdi;
   logic        busy, done;
   logic [7:0]  command_count;
   logic [23:0] readback_data;
   logic        readback_valid;

   afe_config_sequencer #(
      .CLK_DIV(D), .NUM_COMMANDS(NC), .END_MARKER(EM), .GAP_CYCLES(G)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .rom_address(rom_address), .rom_command(rom_command),
      .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
      .busy(busy), .done(done), .command_count(command_count),
      .readback_data(readback_data), .readback_valid(readback_valid)
   );

   initial forever #5 clk = ~clk;

   logic [23:0] rom [256];
   always @(posedge clk) rom_command <= rom[rom_address];

   // AFE side: shifts TXW out on falling SCLK, reloads whenever CSN is high.
   logic [23:0] afe_tx = TXW;
   always @(negedge spi_sclk or posedge spi_csn)
      if (spi_csn) afe_tx <= TXW;
      else         afe_tx <= {afe_tx[22:0], 1'b0};
   assign spi_sdi = afe_tx[23];

   int edge_n = 0;
   initial forever begin
      @(posedge clk);
      edge_n++;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // ---------------- timeline model ----------------
   typedef struct packed {
      logic        busy, done, csn, sclk, sdo, rbv;
      logic [7:0]  cnt, addr;
      logic [23:0] rbd;
   } obs_t;

   bit          in_run = 1'b0;
   int          start_edge = 0;
   int          rst_edge = 0;
   logic [23:0] run_words [256];
   int          run_n = 0;
   bit          run_marker = 1'b0;
   logic [7:0]  prev_cnt = '0, prev_addr = '0;
   logic [23:0] prev_rb = '0;

   function automatic obs_t model_at(input int e);
      obs_t o;
      int k, s, u, c, ai, dk, ninc, bi;
      int L, P;
      logic [23:0] w;
      o = '0;
      o.csn = 1'b1;
      if (!in_run || (rst_edge > start_edge && e >= rst_edge)) return o;
      k = e - start_edge;
      if (k < 0) begin
         o.cnt = prev_cnt; o.addr = prev_addr; o.rbd = prev_rb;
         return o;
      end
      L = 48 * D;
      P = L + G + 2;
      dk   = run_marker ? 2 + run_n * P : 2 + (run_n - 1) * P + L + G;
      ninc = run_marker ? run_n : run_n - 1;
      c = 0; ai = 0;
      for (int j = 0; j < run_n; j++) begin
         s = 2 + j * P;
         if (k >= s && k < s + L) begin
            u = k - s;
            w = run_words[j];
            bi = 23 - u / (2 * D);
            o.csn  = 1'b0;
            o.sclk = (u % (2 * D)) >= D;
            o.sdo  = w[bi];
         end
         if (k >= s + L) c++;
         if (k == s + L) o.rbv = RB;
         if (j < ninc && k >= s + L + G) ai++;
      end
      o.busy = (k <= dk);
      o.done = (k == dk);
      o.cnt  = 8'(c);
      o.addr = 8'(ai);
      o.rbd  = (RB && c > 0) ? TXW : prev_rb;
      return o;
   endfunction

   bit chk_on = 1'b0;
   initial forever begin
      obs_t exp_o, act_o;
      @(negedge clk);
      if (chk_on) begin
         exp_o = model_at(edge_n);
         act_o = '{busy: busy, done: done, csn: spi_csn, sclk: spi_sclk, sdo: spi_sdo,
                   rbv: readback_valid, cnt: command_count, addr: rom_address, rbd: readback_data};
         total++;
         if (act_o !== exp_o) begin
            bad++;
            $display("FAIL cycle %0d: got busy/done/csn/sclk/sdo/rbv=%b%b%b%b%b%b cnt=%0d addr=%0d rbd=%h expected %b%b%b%b%b%b cnt=%0d addr=%0d rbd=%h",
                     edge_n, act_o.busy, act_o.done, act_o.csn, act_o.sclk, act_o.sdo, act_o.rbv,
                     act_o.cnt, act_o.addr, act_o.rbd, exp_o.busy, exp_o.done, exp_o.csn,
                     exp_o.sclk, exp_o.sdo, exp_o.rbv, exp_o.cnt, exp_o.addr, exp_o.rbd);
         end
      end
   end

   // ---------------- independent SPI receiver ----------------
   logic [23:0] frames [$];
   int          widths [$];
   logic [23:0] rx = '0;
   logic [23:0] rb_last = '0;
   int low_w = 0, high_w = 0, min_gap = 1000, done_cnt = 0, rbv_cnt = 0;
   logic p_csn = 1'b1, p_sclk = 1'b0;

   initial forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (readback_valid === 1'b1) begin
         rbv_cnt++;
         rb_last = readback_data;
      end
      if (spi_csn === 1'b0) begin
         if (p_csn === 1'b1) begin
            if (frames.size() > 0 && high_w < min_gap) min_gap = high_w;
            low_w = 0;
         end
         low_w++;
         if (spi_sclk === 1'b1 && p_sclk === 1'b0) rx = {rx[22:0], spi_sdo};
      end else begin
         if (p_csn === 1'b0) begin
            frames.push_back(rx);
            widths.push_back(low_w);
            high_w = 0;
         end
         high_w++;
      end
      p_csn  = spi_csn;
      p_sclk = spi_sclk;
   end

   task automatic clear_mon();
      frames.delete();
      widths.delete();
      min_gap  = 1000;
      done_cnt = 0;
      rbv_cnt  = 0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_start();
      obs_t p;
      p = model_at(edge_n);
      prev_cnt = p.cnt; prev_addr = p.addr; prev_rb = p.rbd;
      run_n = 0;
      run_marker = 1'b0;
      for (int a = 0; a < NC; a++) begin
         if (rom[a] == EM) begin
            run_marker = 1'b1;
            break;
         end
         run_words[run_n] = rom[a];
         run_n++;
      end
      start_edge = edge_n + 1;
      in_run = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_k(input int k);
      while (edge_n - start_edge < k) step(1);
   endtask

   task automatic wait_done(input int budget, input string nm, output int lat);
      bit seen;
      seen = 1'b0;
      lat = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            lat = edge_n - start_edge;
            break;
         end
      end
      chk({nm, "_done_seen"}, int'(seen), 1);
   endtask

   task automatic load_rom_t1();
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[0] = 24'h800001;
      rom[1] = 24'h012345;
      rom[2] = 24'hFFFFFF;
   endtask

   initial begin
      int lat;
      load_rom_t1();
      reset_n = 1'b0;
      start   = 1'b0;
      step(3);
      chk_on  = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset_csn", int'(spi_csn), 1);
      chk("reset_busy", int'(busy), 0);
      step(4);

      // Two frames terminated by the end marker.
      clear_mon();
      do_start();
      wait_done(1000, "t1", lat);
      chk("t1_done_latency", lat, 206);
      chk("t1_busy_at_done", int'(busy), 1);
      step(1);
      @(negedge clk);
      chk("t1_busy_after_done", int'(busy), 0);
      step(6);
      chk("t1_frames", frames.size(), 2);
      chk("t1_word0", int'(frames[0]), 32'h800001);
      chk("t1_word1", int'(frames[1]), 32'h012345);
      chk("t1_csn_low0", widths[0], 96);
      chk("t1_csn_low1", widths[1], 96);
      chk("t1_gap_min_ok", int'(min_gap >= 4), 1);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_count", int'(command_count), 2);
      chk("t1_addr", int'(rom_address), 2);
`ifdef AFE_CFG_READBACK_EN
      chk("t1_rb_pulses", rbv_cnt, 2);
      chk("t1_rb_data", int'(rb_last), 32'hA5C3F0);
`else
      chk("t1_rb_pulses", rbv_cnt, 0);
      chk("t1_rb_data", int'(readback_data), 0);
`endif

      // No end marker: walk stops at NUM_COMMANDS.
      for (int i = 0; i < 256; i++) rom[i] = 24'(i * 24'h111111 + 1);
      clear_mon();
      do_start();
      wait_done(2000, "t2", lat);
      step(8);
      chk("t2_frames", frames.size(), 8);
      chk("t2_word7", int'(frames[7]), 32'h777778);
      chk("t2_count", int'(command_count), 8);
      chk("t2_addr", int'(rom_address), 7);
      chk("t2_done_pulses", done_cnt, 1);

      // End marker at address 0.
      rom[0] = EM;
      clear_mon();
      do_start();
      wait_done(50, "t3", lat);
      chk("t3_done_cycles_after_start", lat + 1, 3);
      step(8);
      chk("t3_frames", frames.size(), 0);
      chk("t3_count", int'(command_count), 0);
      chk("t3_addr", int'(rom_address), 0);

      // Reset during bit 10 of the first frame, then a full replay with ignored starts.
      load_rom_t1();
      do_start();
      wait_k(54);
      reset_n  = 1'b0;
      rst_edge = edge_n + 1;
      step(1);
      reset_n = 1'b1;
      @(negedge clk);
      chk("t4_rst_csn", int'(spi_csn), 1);
      chk("t4_rst_sclk", int'(spi_sclk), 0);
      chk("t4_rst_busy", int'(busy), 0);
      step(3);
      clear_mon();
      do_start();
      wait_k(150);
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_k(206);
      chk("t4_done_on_time", int'(done), 1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      chk("t4_frames", frames.size(), 2);
      chk("t4_word0", int'(frames[0]), 32'h800001);
      chk("t4_word1", int'(frames[1]), 32'h012345);
      chk("t4_done_pulses", done_cnt, 1);
      chk("t4_idle_after", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
